// File: rtl/lbist_stumps_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lbist_stumps_ctrl
// Purpose  : STUMPS logic-BIST controller. An LFSR pattern generator feeds
//            NUM_CHAINS scan chains through repeated shift/capture cycles for a
//            programmable number of patterns. Chain outputs are compacted into
//            a MISR, which is checked against a golden signature at the end.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            bist_start, bist_abort    - run control
//            num_patterns, golden_sig  - run setup, latched at start
//            scan_en, scan_in          - to the core's SE / SI pins
//            scan_out                  - from the core's SO pins
//            bist_busy, bist_done,
//            bist_pass, signature      - status and result
// Revision : 1.0 - initial release
// ============================================================================
module lbist_stumps_ctrl #(
    parameter int                NUM_CHAINS = 4,
    parameter int                CHAIN_LEN  = 16,
    parameter int                PAT_CNT_W  = 10,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY  = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'h0001,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = 16'hB400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bist_start,
    input  logic                  bist_abort,
    input  logic [PAT_CNT_W-1:0]  num_patterns,
    input  logic [MISR_W-1:0]     golden_sig,
    output logic                  scan_en,
    output logic [NUM_CHAINS-1:0] scan_in,
    input  logic [NUM_CHAINS-1:0] scan_out,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_pass,
    output logic [MISR_W-1:0]     signature
);

    localparam int                 c_SHIFT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [c_SHIFT_W-1:0] c_LAST_SHIFT = c_SHIFT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_UNLOAD  = 3'd4,
        S_COMPARE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [LFSR_W-1:0]      r_lfsr;
    logic [MISR_W-1:0]      r_misr;
    logic [MISR_W-1:0]      r_golden_q;
    logic [PAT_CNT_W-1:0]   r_num_q;
    logic [PAT_CNT_W-1:0]   r_pat_cnt;
    logic [c_SHIFT_W-1:0]   r_shift_cnt;
    logic                   r_pass;

    logic                   w_go;
    logic                   w_zero_pat;
    logic                   w_last_shift;
    logic                   w_last_pat;
    logic [LFSR_W-1:0]      w_lfsr_next;
    logic [MISR_W-1:0]      w_misr_next;
    logic [MISR_W-1:0]      w_scan_ext;

    // Start is honoured only when idle or finished, and abort takes priority.
    assign w_go         = bist_start && !bist_abort;
    assign w_zero_pat   = (num_patterns == '0);
    assign w_last_shift = (r_shift_cnt == c_LAST_SHIFT);
    // One extra bit so the compare is exact even for the all-ones count.
    assign w_last_pat   = (({1'b0, r_pat_cnt} + 1'b1) == {1'b0, r_num_q});

    assign w_lfsr_next  = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_POLY)};

    always_comb begin
        w_scan_ext                 = '0;
        w_scan_ext[NUM_CHAINS-1:0] = scan_out;
    end

    assign w_misr_next = {r_misr[MISR_W-2:0], ^(r_misr & MISR_POLY)} ^ w_scan_ext;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go) begin
                    w_next = w_zero_pat ? S_DONE : S_INIT;
                end
            end
            S_INIT: begin
                w_next = bist_abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                if (bist_abort) begin
                    w_next = S_IDLE;
                end else if (w_last_shift) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (bist_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = w_last_pat ? S_UNLOAD : S_SHIFT;
                end
            end
            S_UNLOAD: begin
                if (bist_abort) begin
                    w_next = S_IDLE;
                end else if (w_last_shift) begin
                    w_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_next = bist_abort ? S_IDLE : S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: PRPG, MISR, counters and run setup
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= LFSR_SEED;
            r_misr      <= '0;
            r_golden_q  <= '0;
            r_num_q     <= '0;
            r_pat_cnt   <= '0;
            r_shift_cnt <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        r_num_q    <= num_patterns;
                        r_golden_q <= golden_sig;
                        r_pass     <= 1'b0;
                        // A zero-pattern run reports no stale signature.
                        r_misr     <= '0;
                    end
                end
                S_INIT: begin
                    r_lfsr      <= LFSR_SEED;
                    r_misr      <= '0;
                    r_shift_cnt <= '0;
                    r_pat_cnt   <= '0;
                end
                S_SHIFT: begin
                    r_lfsr <= w_lfsr_next;
                    // The first load flushes unknown chain contents, so it
                    // must not reach the signature.
                    if (r_pat_cnt != '0) begin
                        r_misr <= w_misr_next;
                    end
                    r_shift_cnt <= w_last_shift ? '0 : r_shift_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    r_pat_cnt <= r_pat_cnt + 1'b1;
                end
                S_UNLOAD: begin
                    r_misr      <= w_misr_next;
                    r_shift_cnt <= w_last_shift ? '0 : r_shift_cnt + 1'b1;
                end
                S_COMPARE: begin
                    r_pass <= (r_misr == r_golden_q);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign scan_en   = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
    assign scan_in   = (r_state == S_SHIFT) ? r_lfsr[NUM_CHAINS-1:0] : '0;
    assign bist_busy = (r_state == S_INIT)    || (r_state == S_SHIFT) ||
                       (r_state == S_CAPTURE) || (r_state == S_UNLOAD) ||
                       (r_state == S_COMPARE);
    assign bist_done = (r_state == S_DONE);
    assign bist_pass = r_pass;
    assign signature = r_misr;

endmodule
`default_nettype wire

// File: tb/tb_lbist_stumps_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbist_stumps_ctrl
// Purpose  : Self-checking bench for lbist_stumps_ctrl. A chain model (capture
//            inverts contents) sits on the scan pins; a pattern-level reference
//            model predicts signatures and a cycle-offset model predicts the
//            control outputs of each run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbist_stumps_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bist_start, bist_abort;
    logic [9:0]  num_patterns;
    logic [15:0] golden_sig;
    logic        scan_en;
    logic [3:0]  scan_in, scan_out;
    logic        bist_busy, bist_done, bist_pass;
    logic [15:0] signature;

    logic        bist_start2;
    logic [9:0]  num_patterns2;
    logic [15:0] golden_sig2;
    logic        scan_en2;
    logic [7:0]  scan_in2, scan_out2;
    logic        bist_busy2, bist_done2, bist_pass2;
    logic [15:0] signature2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lbist_stumps_ctrl u_dut (
        .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
        .num_patterns(num_patterns), .golden_sig(golden_sig),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
        .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
        .signature(signature)
    );

    lbist_stumps_ctrl #(.NUM_CHAINS(8), .CHAIN_LEN(5), .PAT_CNT_W(10)) u_dut2 (
        .clk(clk), .rst(rst), .bist_start(bist_start2), .bist_abort(1'b0),
        .num_patterns(num_patterns2), .golden_sig(golden_sig2),
        .scan_en(scan_en2), .scan_in(scan_in2), .scan_out(scan_out2),
        .bist_busy(bist_busy2), .bist_done(bist_done2), .bist_pass(bist_pass2),
        .signature(signature2)
    );

    // Scan chain models: shift when enabled, invert contents on a capture.
    logic [15:0] ch1 [4];
    logic [4:0]  ch2 [8];

    initial begin
        for (int i = 0; i < 4; i++) ch1[i] = '0;
        for (int i = 0; i < 8; i++) ch2[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (scan_en)        ch1[i] <= {ch1[i][14:0], scan_in[i]};
            else if (bist_busy) ch1[i] <= ~ch1[i];
        end
        for (int i = 0; i < 8; i++) begin
            if (scan_en2)        ch2[i] <= {ch2[i][3:0], scan_in2[i]};
            else if (bist_busy2) ch2[i] <= ~ch2[i];
        end
    end

    always_comb begin
        scan_out  = '0;
        scan_out2 = '0;
        for (int i = 0; i < 4; i++) scan_out[i]  = ch1[i][15];
        for (int i = 0; i < 8; i++) scan_out2[i] = ch2[i][4];
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [15:0] lstep(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    // Whole-run signature: chains loaded pattern by pattern from the PRPG,
    // captured by inversion, then unloaded; first load is not compacted.
    function automatic logic [15:0] sig_model(input int nc, input int len, input int npat);
        logic [15:0] ch [8];
        logic [15:0] lf, ms, outv;
        for (int i = 0; i < 8; i++) ch[i] = '0;
        lf = 16'h0001;
        ms = '0;
        for (int p = 0; p < npat; p++) begin
            for (int c = 0; c < len; c++) begin
                outv = '0;
                for (int i = 0; i < nc; i++) outv[i] = ch[i][len-1];
                if (p > 0) ms = lstep(ms) ^ outv;
                for (int i = 0; i < nc; i++) ch[i] = {ch[i][14:0], lf[i]};
                lf = lstep(lf);
            end
            for (int i = 0; i < nc; i++) ch[i] = ~ch[i];
        end
        for (int c = 0; c < len; c++) begin
            outv = '0;
            for (int i = 0; i < nc; i++) outv[i] = ch[i][len-1];
            ms = lstep(ms) ^ outv;
            for (int i = 0; i < nc; i++) ch[i] = {ch[i][14:0], 1'b0};
        end
        return ms;
    endfunction

    logic [15:0] lfsr_tab [0:63];
    initial begin
        lfsr_tab[0] = 16'h0001;
        for (int s = 1; s < 64; s++) lfsr_tab[s] = lstep(lfsr_tab[s-1]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Run tracking: k = cycles since the start edge, driven at posedge.
    // ------------------------------------------------------------------
    logic        start_pending = 1'b0;
    logic        kill          = 1'b0;
    logic        trk           = 1'b0;
    int          k             = 0;
    int          exp_n         = 0;
    logic [15:0] exp_sig       = '0;
    logic        exp_pass      = 1'b0;

    always @(posedge clk) begin
        if (start_pending) begin
            trk <= 1'b1;
            k   <= 1;
        end else if (trk) begin
            if (kill || k >= 1 + exp_n*17 + 16 + 2) trk <= 1'b0;
            else                                   k   <= k + 1;
        end
    end

    // Compare process: control outputs from the cycle offset within the run.
    always @(negedge clk) begin
        if (trk) begin
            int t, p, j;
            logic e_en;
            logic [3:0] e_si;
            t    = 1 + exp_n*17 + 16 + 1;
            e_en = 1'b0;
            e_si = '0;
            if (k >= 2 && k <= exp_n*17 + 1) begin
                p    = (k - 2) / 17;
                j    = (k - 2) % 17;
                e_en = (j < 16);
                if (j < 16) e_si = lfsr_tab[p*16 + j][3:0];
            end else if (k > exp_n*17 + 1 && k < t) begin
                e_en = 1'b1;
            end
            if (k <= t) begin
                chk("busy",    32'(bist_busy), 32'(k >= 1));
                chk("done",    32'(bist_done), 32'd0);
                chk("scan_en", 32'(scan_en),   32'(e_en));
                chk("scan_in", 32'(scan_in),   32'(e_si));
            end else begin
                chk("done_end",  32'(bist_done), 32'd1);
                chk("busy_end",  32'(bist_busy), 32'd0);
                chk("pass",      32'(bist_pass), 32'(exp_pass));
                chk("signature", 32'(signature), 32'(exp_sig));
            end
            if (k == 2)                       chk("scan_in_first", 32'(scan_in), 32'h1);
            if (k == 18 || k == 35 || k == 52) chk("capture_en_low", 32'(scan_en), 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called from negedge context)
    // ------------------------------------------------------------------
    task automatic begin_run(input int n, input logic [15:0] gold, input logic epass);
        exp_n        = n;
        exp_sig      = sig_model(4, 16, n);
        exp_pass     = epass;
        num_patterns = 10'(n);
        golden_sig   = gold;
        @(negedge clk);
        bist_start    = 1'b1;
        start_pending = 1'b1;
        @(negedge clk);
        bist_start    = 1'b0;
        start_pending = 1'b0;
    endtask

    // Runs to completion, pulsing bist_start at offsets pa/pb; returns busy cycles.
    task automatic do_run(input int n, input logic [15:0] gold, input logic epass,
                          input int pa, input int pb, output int nb);
        bit fin;
        begin_run(n, gold, epass);
        nb  = bist_busy ? 1 : 0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            bist_start = (k == pa || k == pb) && trk;
            @(negedge clk);
            bist_start = 1'b0;
            if (bist_busy) nb++;
            if (bist_done) fin = 1'b1;
        end
        if (!fin) chk("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_k(input int target);
        for (int c = 0; c < 200 && k != target; c++) @(negedge clk);
        if (k != target) chk("wait_k_timeout", 32'(k), 32'(target));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int nb;
        logic [15:0] sig1, sig6;
        rst = 1'b1; bist_start = 1'b0; bist_abort = 1'b0;
        num_patterns = '0; golden_sig = '0;
        bist_start2 = 1'b0; num_patterns2 = '0; golden_sig2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_scan_en",  32'(scan_en),   32'd0);
        chk("rst_scan_in",  32'(scan_in),   32'd0);
        chk("rst_busy",     32'(bist_busy), 32'd0);
        chk("rst_done",     32'(bist_done), 32'd0);
        chk("rst_pass",     32'(bist_pass), 32'd0);
        chk("rst_sig",      32'(signature), 32'd0);
        chk("rst2_busy",    32'(bist_busy2), 32'd0);
        chk("rst2_sig",     32'(signature2), 32'd0);
        rst = 1'b0;

        // Pin the PRPG model with hand-stepped values from seed 0x0001.
        chk("model_lfsr1",  32'(lfsr_tab[1]),  32'h0002);
        chk("model_lfsr10", 32'(lfsr_tab[10]), 32'h0400);
        chk("model_lfsr11", 32'(lfsr_tab[11]), 32'h0801);

        // 1: N=3, matching golden
        sig1 = sig_model(4, 16, 3);
        do_run(3, sig1, 1'b1, -1, -1, nb);
        chk("t1_busy_cycles", 32'(nb), 32'd69);
        repeat (3) @(negedge clk);
        chk("t1_done_held", 32'(bist_done), 32'd1);
        chk("t1_sig_held",  32'(signature), 32'(sig1));

        // 2: wrong golden
        do_run(3, sig1 ^ 16'h0001, 1'b0, -1, -1, nb);
        chk("t2_busy_cycles", 32'(nb), 32'd69);
        chk("t2_sig", 32'(signature), 32'(sig1));

        // 3: zero patterns
        num_patterns = '0;
        @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        chk("t3_done",    32'(bist_done), 32'd1);
        chk("t3_pass",    32'(bist_pass), 32'd0);
        chk("t3_busy",    32'(bist_busy), 32'd0);
        nb = 0;
        for (int c = 0; c < 5; c++) begin
            if (scan_en) nb++;
            @(negedge clk);
        end
        chk("t3_scan_en_never", 32'(nb), 32'd0);

        // Abort wins over a simultaneous start.
        num_patterns = 10'd3;
        bist_start = 1'b1; bist_abort = 1'b1;
        @(negedge clk);
        bist_start = 1'b0; bist_abort = 1'b0;
        chk("abort_wins_busy", 32'(bist_busy), 32'd0);

        // 4: abort in the 5th SHIFT cycle of pattern 2 (offset 23)
        begin_run(3, sig1, 1'b1);
        wait_k(23);
        bist_abort = 1'b1; kill = 1'b1;
        @(negedge clk);
        bist_abort = 1'b0; kill = 1'b0;
        chk("t4_busy",    32'(bist_busy), 32'd0);
        chk("t4_done",    32'(bist_done), 32'd0);
        chk("t4_scan_en", 32'(scan_en),   32'd0);
        repeat (2) @(negedge clk);
        chk("t4_idle_busy", 32'(bist_busy), 32'd0);
        do_run(3, sig1, 1'b1, -1, -1, nb);
        chk("t4_rerun_sig", 32'(signature), 32'(sig1));

        // 5: reset during CAPTURE (offset 18)
        begin_run(3, sig1, 1'b1);
        wait_k(18);
        rst = 1'b1; kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("t5_scan_en", 32'(scan_en),   32'd0);
        chk("t5_scan_in", 32'(scan_in),   32'd0);
        chk("t5_busy",    32'(bist_busy), 32'd0);
        chk("t5_done",    32'(bist_done), 32'd0);
        chk("t5_pass",    32'(bist_pass), 32'd0);
        chk("t5_sig",     32'(signature), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_run(3, sig1, 1'b1, 10, 40, nb);
        chk("t5_busy_cycles", 32'(nb), 32'd69);

        // 6: 8 chains x 5 flops, 1023 patterns
        sig6 = sig_model(8, 5, 1023);
        num_patterns2 = 10'd1023;
        golden_sig2   = sig6;
        @(negedge clk);
        bist_start2 = 1'b1;
        @(negedge clk);
        bist_start2 = 1'b0;
        nb = bist_busy2 ? 1 : 0;
        for (int c = 0; c < 7000 && !bist_done2; c++) begin
            @(negedge clk);
            if (bist_busy2) nb++;
        end
        chk("t6_done",        32'(bist_done2), 32'd1);
        chk("t6_busy_cycles", 32'(nb),         32'd6145);
        chk("t6_pass",        32'(bist_pass2), 32'd1);
        chk("t6_sig",         32'(signature2), 32'(sig6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
